tt6502_bus_sequencer: RTL and testbench
=======================================

// Module: tt6502_bus_sequencer
// PURPOSE
//  Time-multiplexes 16-bit-address / 8-bit-data memory cycles onto the tile's narrow pad set
//  (8 dedicated outputs + 8 bidir IOs) for the 6502 core and the debug/loader port.
//  Arbitrates the two requesters round-robin and sequences each access as: addr-lo, addr-hi, data.
//  Sits between the CPU core/debug port and tt_um_anders_tt_6502 pad mapping.
// PARAMETERS
//  ADDR_W       16  requester address width (must be 16; two 8-bit address phases)
//  DATA_W        8  data width (must be 8; equals bidir pad width)
//  WAIT_CYCLES   0  extra DATA-phase cycles before read sample / write release (0..15)
// PORTS
//  clk          in   1   single clock, all state on rising edge
//  rst          in   1   synchronous, active-high reset
//  cpu_req      in   1   CPU access request; hold until cpu_ack
//  cpu_we       in   1   1=write, 0=read
//  cpu_addr     in   16  CPU address
//  cpu_wdata    in   8   CPU write data
//  cpu_rdata    out  8   read data, valid in cpu_ack cycle, held until next CPU read completes
//  cpu_ack      out  1   one-cycle completion pulse
//  dbg_req/dbg_we/dbg_addr/dbg_wdata/dbg_rdata/dbg_ack   same as cpu_* for debug/loader port
//  pad_addr     out  8   address byte to dedicated outputs
//  pad_phase    out  2   00 idle, 01 addr-lo, 10 addr-hi, 11 data
//  pad_we       out  1   registered we of current transaction; 0 outside transaction
//  pad_io_in    in   8   bidir pad input path
//  pad_io_out   out  8   bidir pad output path (write data)
//  pad_io_oe    out  8   bidir enable, all-ones only in write DATA phase, else 0
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (pad_phase=00, pad_io_oe=00, acks 0, rdata regs 0);
//   rr pointer = "last granted DBG" so CPU wins first tie. rst mid-transaction: next edge IDLE,
//   oe released, no ack issued, transaction abandoned.
//  FSM: IDLE -> ALO -> AHI -> DATA (1+WAIT_CYCLES cycles, counter) -> ACK -> IDLE.
//  IDLE: if any req, grant per arbiter; latch id, we, addr, wdata; go ALO. Latched copies are
//   used for the whole transaction (requester changes after grant are ignored).
//  ALO: pad_phase=01, pad_addr=addr[7:0]. AHI: pad_phase=10, pad_addr=addr[15:8].
//  DATA: pad_phase=11, pad_addr=addr[15:8] held. Write: pad_io_out=wdata, pad_io_oe=FF.
//   Read: oe=00; pad_io_in sampled on the final DATA edge into granted port's rdata reg.
//  ACK: granted port's ack=1 exactly one cycle; pad_phase=00, oe=00 (turnaround). Next IDLE.
//  Latency: req high in IDLE cycle t -> ack in cycle t+4+WAIT_CYCLES; 5+W cycles per access.
//   Back-to-back: req still high in IDLE after ack = new transaction (requester drops req on ack).
//  Arbitration: only CPU req -> CPU; only DBG -> DBG; both -> requester not granted last;
//   pointer updates on every grant. No preemption; dbg cannot interrupt an active CPU access.
//  Req dropped before ack: transaction still completes and acks (no cancel).
//  All pad outputs registered (no comb path from req/addr to pads). Non-granted ack stays 0;
//   non-granted rdata unchanged.
// STRUCTURE
//  Shared defines file tt6502_bus_defs.vh (used as package): FSM state encodings, PHASE_*
//   codes, REQ_CPU/REQ_DBG ids. Also consumed by top-level pad mapping and bench.
//  One sub-module: tt6502_rr_arb2 (2-way round-robin, grant + pointer update on accept).
//  Sequencer FSM, wait counter, latch regs and pad regs live in this module.
// TESTING
//  1 CPU read 0x12AB, W=0, pad_io_in=0x5A in DATA -> phases 01/AB,10/12,11; oe=00;
//    cpu_ack 4 cycles after req cycle, cpu_rdata=0x5A; dbg_ack stays 0.
//  2 DBG write 0xFFFF<=0xC3, W=2 -> DATA 3 cycles with oe=FF, io_out=C3; oe=00 in ACK;
//    dbg_ack at cycle t+6.
//  3 Both req held continuously -> grants alternate CPU,DBG,CPU,DBG; each ack one cycle wide.
//  4 CPU changes addr/wdata to 0x0000/0x00 after grant -> pads still show latched values.
//  5 rst asserted in DATA of a write -> next cycle phase=00, oe=00, no ack; post-reset
//    simultaneous req grants CPU first.
//  6 cpu_req dropped in AHI -> access completes, cpu_ack still pulses, no second access.

Source files
------------

// File: rtl/tt6502_bus_sequencer_pkg.sv
// Shared types for the tt6502 bus sequencer: FSM states, pad phase codes and requester ids.
// Imported by the sequencer, its arbiter, the pad mapping and the bench.
package tt6502_bus_sequencer_pkg;

    localparam int unsigned BUS_ADDR_W = 16;
    localparam int unsigned BUS_DATA_W = 8;
    localparam int unsigned WAIT_CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ALO  = 3'd1,
        ST_AHI  = 3'd2,
        ST_DATA = 3'd3,
        ST_ACK  = 3'd4
    } seq_state_e;

    typedef enum logic [1:0] {
        PHASE_IDLE = 2'b00,
        PHASE_ALO  = 2'b01,
        PHASE_AHI  = 2'b10,
        PHASE_DATA = 2'b11
    } pad_phase_e;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DBG = 1'b1
    } req_id_e;

endpackage

// File: rtl/tt6502_bus_sequencer_if.sv
// Requester-side memory handshake bundle; one instance each for the CPU and debug/loader port.
interface tt6502_bus_sequencer_if ();
    import tt6502_bus_sequencer_pkg::*;

    logic                  req;
    logic                  we;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] wdata;
    logic [BUS_DATA_W-1:0] rdata;
    logic                  ack;

    modport master (output req, output we, output addr, output wdata,
                    input  rdata, input ack);
    modport slave  (input  req, input  we, input  addr, input  wdata,
                    output rdata, output ack);
endinterface

// File: rtl/tt6502_bus_sequencer_rr_arb2.sv
// Two-way round-robin arbiter between CPU and debug port; pointer advances only on an accepted grant.
module tt6502_rr_arb2
    import tt6502_bus_sequencer_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    req_cpu,
    input  logic    req_dbg,
    input  logic    accept,
    output logic    grant_valid,
    output req_id_e grant_id
);

    logic last_dbg_q;
    logic last_dbg_d;

    // On a tie the requester that did not win last time is chosen.
    always_comb begin
        grant_valid = req_cpu | req_dbg;
        grant_id    = (req_dbg && (!req_cpu || !last_dbg_q)) ? REQ_DBG : REQ_CPU;
        last_dbg_d  = last_dbg_q;
        if (accept) begin
            last_dbg_d = (grant_id == REQ_DBG);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_dbg_q <= 1'b1;
        end else begin
            last_dbg_q <= last_dbg_d;
        end
    end

endmodule

// File: rtl/tt6502_bus_sequencer.sv
// Multiplexes 16-bit-address / 8-bit-data accesses from the CPU and debug port onto the pad set
// as addr-lo, addr-hi and data phases; every pad output is registered.
module tt6502_bus_sequencer
    import tt6502_bus_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    tt6502_bus_sequencer_if.slave  cpu,
    tt6502_bus_sequencer_if.slave  dbg,
    output logic [7:0]             pad_addr,
    output logic [1:0]             pad_phase,
    output logic                   pad_we,
    input  logic [DATA_W-1:0]      pad_io_in,
    output logic [DATA_W-1:0]      pad_io_out,
    output logic [DATA_W-1:0]      pad_io_oe
);

    seq_state_e              state_q,      state_d;
    req_id_e                 id_q,         id_d;
    logic                    we_q,         we_d;
    logic [ADDR_W-1:0]       addr_q,       addr_d;
    logic [DATA_W-1:0]       wdata_q,      wdata_d;
    logic [WAIT_CNT_W-1:0]   wait_cnt_q,   wait_cnt_d;
    pad_phase_e              pad_phase_q,  pad_phase_d;
    logic [7:0]              pad_addr_q,   pad_addr_d;
    logic                    pad_we_q,     pad_we_d;
    logic [DATA_W-1:0]       pad_io_out_q, pad_io_out_d;
    logic [DATA_W-1:0]       pad_io_oe_q,  pad_io_oe_d;
    logic                    cpu_ack_q,    cpu_ack_d;
    logic                    dbg_ack_q,    dbg_ack_d;
    logic [DATA_W-1:0]       cpu_rdata_q,  cpu_rdata_d;
    logic [DATA_W-1:0]       dbg_rdata_q,  dbg_rdata_d;

    logic                    grant_valid;
    req_id_e                 grant_id;
    logic                    accept;
    logic                    sel_we;
    logic [ADDR_W-1:0]       sel_addr;
    logic [DATA_W-1:0]       sel_wdata;

    assign accept = (state_q == ST_IDLE) && grant_valid;

    tt6502_rr_arb2 u_arb (
        .clk         (clk),
        .rst         (rst),
        .req_cpu     (cpu.req),
        .req_dbg     (dbg.req),
        .accept      (accept),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        sel_we    = (grant_id == REQ_DBG) ? dbg.we    : cpu.we;
        sel_addr  = (grant_id == REQ_DBG) ? dbg.addr  : cpu.addr;
        sel_wdata = (grant_id == REQ_DBG) ? dbg.wdata : cpu.wdata;
    end

    // Pad registers are loaded with the values of the state being entered, so they line up with state_q.
    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wait_cnt_d   = wait_cnt_q;
        pad_phase_d  = pad_phase_q;
        pad_addr_d   = pad_addr_q;
        pad_we_d     = pad_we_q;
        pad_io_out_d = pad_io_out_q;
        pad_io_oe_d  = pad_io_oe_q;
        cpu_ack_d    = 1'b0;
        dbg_ack_d    = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        dbg_rdata_d  = dbg_rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_d     = ST_ALO;
                    id_d        = grant_id;
                    we_d        = sel_we;
                    addr_d      = sel_addr;
                    wdata_d     = sel_wdata;
                    pad_phase_d = PHASE_ALO;
                    pad_addr_d  = sel_addr[7:0];
                    pad_we_d    = sel_we;
                end
            end
            ST_ALO: begin
                state_d     = ST_AHI;
                pad_phase_d = PHASE_AHI;
                pad_addr_d  = addr_q[ADDR_W-1:8];
                wait_cnt_d  = '0;
            end
            ST_AHI: begin
                state_d     = ST_DATA;
                pad_phase_d = PHASE_DATA;
                if (we_q) begin
                    pad_io_out_d = wdata_q;
                    pad_io_oe_d  = '1;
                end
            end
            ST_DATA: begin
                if (wait_cnt_q == WAIT_CYCLES[WAIT_CNT_W-1:0]) begin
                    state_d      = ST_ACK;
                    pad_phase_d  = PHASE_IDLE;
                    pad_addr_d   = '0;
                    pad_we_d     = 1'b0;
                    pad_io_out_d = '0;
                    pad_io_oe_d  = '0;
                    if (id_q == REQ_DBG) begin
                        dbg_ack_d = 1'b1;
                        if (!we_q) dbg_rdata_d = pad_io_in;
                    end else begin
                        cpu_ack_d = 1'b1;
                        if (!we_q) cpu_rdata_d = pad_io_in;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            id_q         <= REQ_CPU;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wait_cnt_q   <= '0;
            pad_phase_q  <= PHASE_IDLE;
            pad_addr_q   <= '0;
            pad_we_q     <= 1'b0;
            pad_io_out_q <= '0;
            pad_io_oe_q  <= '0;
            cpu_ack_q    <= 1'b0;
            dbg_ack_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wait_cnt_q   <= wait_cnt_d;
            pad_phase_q  <= pad_phase_d;
            pad_addr_q   <= pad_addr_d;
            pad_we_q     <= pad_we_d;
            pad_io_out_q <= pad_io_out_d;
            pad_io_oe_q  <= pad_io_oe_d;
            cpu_ack_q    <= cpu_ack_d;
            dbg_ack_q    <= dbg_ack_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    assign pad_phase  = pad_phase_q;
    assign pad_addr   = pad_addr_q;
    assign pad_we     = pad_we_q;
    assign pad_io_out = pad_io_out_q;
    assign pad_io_oe  = pad_io_oe_q;
    assign cpu.ack    = cpu_ack_q;
    assign cpu.rdata  = cpu_rdata_q;
    assign dbg.ack    = dbg_ack_q;
    assign dbg.rdata  = dbg_rdata_q;

endmodule

// File: tb/tb_tt6502_bus_sequencer.sv
// Directed bench for tt6502_bus_sequencer: per-cycle vector table on a zero-wait instance,
// plus hand sequences for mid-write reset and a two-wait-cycle debug write.
module tb_tt6502_bus_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, rst2;
    logic [7:0] pad_addr0, pad_addr2;
    logic [1:0] pad_phase0, pad_phase2;
    logic       pad_we0, pad_we2;
    logic [7:0] pad_io_in0, pad_io_in2;
    logic [7:0] pad_io_out0, pad_io_out2;
    logic [7:0] pad_io_oe0, pad_io_oe2;

    tt6502_bus_sequencer_if cpu0 ();
    tt6502_bus_sequencer_if dbg0 ();
    tt6502_bus_sequencer_if cpu2 ();
    tt6502_bus_sequencer_if dbg2 ();

    tt6502_bus_sequencer #(.ADDR_W(16), .DATA_W(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst0), .cpu(cpu0), .dbg(dbg0),
        .pad_addr(pad_addr0), .pad_phase(pad_phase0), .pad_we(pad_we0),
        .pad_io_in(pad_io_in0), .pad_io_out(pad_io_out0), .pad_io_oe(pad_io_oe0)
    );

    tt6502_bus_sequencer #(.ADDR_W(16), .DATA_W(8), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst2), .cpu(cpu2), .dbg(dbg2),
        .pad_addr(pad_addr2), .pad_phase(pad_phase2), .pad_we(pad_we2),
        .pad_io_in(pad_io_in2), .pad_io_out(pad_io_out2), .pad_io_oe(pad_io_oe2)
    );

    typedef struct {
        logic       rst;
        logic       creq, cwe;
        logic [15:0] caddr;
        logic [7:0] cwd;
        logic       dreq, dwe;
        logic [15:0] daddr;
        logic [7:0] dwd, io;
        logic [1:0] ph;
        logic [7:0] pa;
        logic       pwe;
        logic [7:0] oe, iout;
        logic       cack, dack;
        logic [7:0] crd, drd;
    } vec_t;

    vec_t vecs[$];
    vec_t cur;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drv(input int r, input int c, input int cw, input int ca, input int cd,
                       input int d, input int dw, input int da, input int dd, input int io);
        cur.rst = r[0];  cur.creq = c[0];  cur.cwe = cw[0];  cur.caddr = ca[15:0]; cur.cwd = cd[7:0];
        cur.dreq = d[0]; cur.dwe = dw[0];  cur.daddr = da[15:0]; cur.dwd = dd[7:0];  cur.io = io[7:0];
    endtask

    task automatic ex(input int ph, input int pa, input int pwe, input int oe, input int iout,
                      input int cack, input int dack, input int crd, input int drd);
        cur.ph = ph[1:0]; cur.pa = pa[7:0]; cur.pwe = pwe[0]; cur.oe = oe[7:0]; cur.iout = iout[7:0];
        cur.cack = cack[0]; cur.dack = dack[0]; cur.crd = crd[7:0]; cur.drd = drd[7:0];
        vecs.push_back(cur);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        bit   cack_seen, dack_seen;
        int   e_ph, e_oe;

        rst0 = 1'b1; rst2 = 1'b1;
        pad_io_in0 = '0; pad_io_in2 = '0;
        cpu0.req = 0; cpu0.we = 0; cpu0.addr = '0; cpu0.wdata = '0;
        dbg0.req = 0; dbg0.we = 0; dbg0.addr = '0; dbg0.wdata = '0;
        cpu2.req = 0; cpu2.we = 0; cpu2.addr = '0; cpu2.wdata = '0;
        dbg2.req = 0; dbg2.we = 0; dbg2.addr = '0; dbg2.wdata = '0;

        // reset
        drv(1, 0,0,0,0, 0,0,0,0, 0);            ex(0,0,0,0,0, 0,0,0,0);
        // CPU read 0x12AB, 0x5A on the pads in DATA
        drv(0, 1,0,'h12AB,0, 0,0,0,0, 0);       ex(1,'hAB,0,0,0, 0,0,0,0);
                                                ex(2,'h12,0,0,0, 0,0,0,0);
                                                ex(3,'h12,0,0,0, 0,0,0,0);
        drv(0, 1,0,'h12AB,0, 0,0,0,0, 'h5A);    ex(0,0,0,0,0, 1,0,'h5A,0);
        drv(0, 0,0,'h12AB,0, 0,0,0,0, 0);       ex(0,0,0,0,0, 0,0,'h5A,0);
        // reset clears rdata; both requesters then held: CPU, DBG, CPU, DBG
        drv(1, 0,0,0,0, 0,0,0,0, 0);            ex(0,0,0,0,0, 0,0,0,0);
        drv(0, 1,0,'h1234,0, 1,1,'hBEEF,'h3C, 0); ex(1,'h34,0,0,0, 0,0,0,0);
                                                ex(2,'h12,0,0,0, 0,0,0,0);
                                                ex(3,'h12,0,0,0, 0,0,0,0);
        drv(0, 1,0,'h1234,0, 1,1,'hBEEF,'h3C, 'h99); ex(0,0,0,0,0, 1,0,'h99,0);
                                                ex(0,0,0,0,0, 0,0,'h99,0);
                                                ex(1,'hEF,1,0,0, 0,0,'h99,0);
                                                ex(2,'hBE,1,0,0, 0,0,'h99,0);
                                                ex(3,'hBE,1,'hFF,'h3C, 0,0,'h99,0);
                                                ex(0,0,0,0,0, 0,1,'h99,0);
                                                ex(0,0,0,0,0, 0,0,'h99,0);
                                                ex(1,'h34,0,0,0, 0,0,'h99,0);
                                                ex(2,'h12,0,0,0, 0,0,'h99,0);
                                                ex(3,'h12,0,0,0, 0,0,'h99,0);
        drv(0, 1,0,'h1234,0, 1,1,'hBEEF,'h3C, 'h42); ex(0,0,0,0,0, 1,0,'h42,0);
                                                ex(0,0,0,0,0, 0,0,'h42,0);
                                                ex(1,'hEF,1,0,0, 0,0,'h42,0);
        drv(0, 0,0,'h1234,0, 0,1,'hBEEF,'h3C, 'h42); ex(2,'hBE,1,0,0, 0,0,'h42,0);
                                                ex(3,'hBE,1,'hFF,'h3C, 0,0,'h42,0);
                                                ex(0,0,0,0,0, 0,1,'h42,0);
                                                ex(0,0,0,0,0, 0,0,'h42,0);
        // CPU write 0x4321<=0xA5, requester inputs scrambled after grant
        drv(0, 1,1,'h4321,'hA5, 0,0,0,0, 0);    ex(1,'h21,1,0,0, 0,0,'h42,0);
        drv(0, 1,1,'h0000,'h00, 0,0,0,0, 0);    ex(2,'h43,1,0,0, 0,0,'h42,0);
                                                ex(3,'h43,1,'hFF,'hA5, 0,0,'h42,0);
                                                ex(0,0,0,0,0, 1,0,'h42,0);
        drv(0, 0,0,'h0000,'h00, 0,0,0,0, 0);    ex(0,0,0,0,0, 0,0,'h42,0);
        // CPU read with req dropped in AHI: still completes, no second access
        drv(0, 1,0,'h00F0,0, 0,0,0,0, 0);       ex(1,'hF0,0,0,0, 0,0,'h42,0);
                                                ex(2,'h00,0,0,0, 0,0,'h42,0);
        drv(0, 0,0,'h00F0,0, 0,0,0,0, 0);       ex(3,'h00,0,0,0, 0,0,'h42,0);
        drv(0, 0,0,'h00F0,0, 0,0,0,0, 'h6E);    ex(0,0,0,0,0, 1,0,'h6E,0);
                                                ex(0,0,0,0,0, 0,0,'h6E,0);
                                                ex(0,0,0,0,0, 0,0,'h6E,0);
        // DBG read: only dbg rdata changes
        drv(0, 0,0,0,0, 1,0,'h0102,0, 0);       ex(1,'h02,0,0,0, 0,0,'h6E,0);
                                                ex(2,'h01,0,0,0, 0,0,'h6E,0);
                                                ex(3,'h01,0,0,0, 0,0,'h6E,0);
        drv(0, 0,0,0,0, 1,0,'h0102,0, 'hD7);    ex(0,0,0,0,0, 0,1,'h6E,'hD7);
        drv(0, 0,0,0,0, 0,0,'h0102,0, 0);       ex(0,0,0,0,0, 0,0,'h6E,'hD7);

        foreach (vecs[i]) begin
            v = vecs[i];
            rst0 = v.rst;
            cpu0.req = v.creq; cpu0.we = v.cwe; cpu0.addr = v.caddr; cpu0.wdata = v.cwd;
            dbg0.req = v.dreq; dbg0.we = v.dwe; dbg0.addr = v.daddr; dbg0.wdata = v.dwd;
            pad_io_in0 = v.io;
            step();
            chk("phase",     i, 16'(pad_phase0),  16'(v.ph));
            chk("pad_addr",  i, 16'(pad_addr0),   16'(v.pa));
            chk("pad_we",    i, 16'(pad_we0),     16'(v.pwe));
            chk("oe",        i, 16'(pad_io_oe0),  16'(v.oe));
            chk("io_out",    i, 16'(pad_io_out0), 16'(v.iout));
            chk("cpu_ack",   i, 16'(cpu0.ack),    16'(v.cack));
            chk("dbg_ack",   i, 16'(dbg0.ack),    16'(v.dack));
            chk("cpu_rdata", i, 16'(cpu0.rdata),  16'(v.crd));
            chk("dbg_rdata", i, 16'(dbg0.rdata),  16'(v.drd));
        end

        // Reset during the DATA phase of a write; then a tie must go to the CPU.
        pad_io_in0 = '0;
        cpu0.req = 1; cpu0.we = 1; cpu0.addr = 16'h5555; cpu0.wdata = 8'h81;
        step(); step(); step();
        chk("t5_phase_data", 0, 16'(pad_phase0), 16'h3);
        chk("t5_oe_data",    0, 16'(pad_io_oe0), 16'hFF);
        chk("t5_out_data",   0, 16'(pad_io_out0), 16'h81);
        rst0 = 1;
        dbg0.req = 1; dbg0.we = 0; dbg0.addr = 16'h7777;
        step();
        chk("t5_phase_rst", 0, 16'(pad_phase0), 16'h0);
        chk("t5_oe_rst",    0, 16'(pad_io_oe0), 16'h00);
        chk("t5_out_rst",   0, 16'(pad_io_out0), 16'h00);
        chk("t5_cack_rst",  0, 16'(cpu0.ack), 16'h0);
        chk("t5_drd_rst",   0, 16'(dbg0.rdata), 16'h00);
        rst0 = 0;
        step();
        chk("t5_phase_alo", 0, 16'(pad_phase0), 16'h1);
        chk("t5_addr_cpu",  0, 16'(pad_addr0), 16'h55);
        chk("t5_we_cpu",    0, 16'(pad_we0), 16'h1);
        chk("t5_cack_alo",  0, 16'(cpu0.ack), 16'h0);
        cpu0.req = 0; dbg0.req = 0;
        cack_seen = 0; dack_seen = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (cpu0.ack === 1'b1) cack_seen = 1;
            if (dbg0.ack === 1'b1) dack_seen = 1;
        end
        chk("t5_cpu_ack_seen", 0, 16'(cack_seen), 16'h1);
        chk("t5_dbg_ack_none", 0, 16'(dack_seen), 16'h0);

        // DBG write 0xFFFF<=0xC3 with two wait cycles: DATA lasts three cycles, ack at t+6.
        step();
        chk("t2_phase_rst", 0, 16'(pad_phase2), 16'h0);
        rst2 = 0;
        dbg2.req = 1; dbg2.we = 1; dbg2.addr = 16'hFFFF; dbg2.wdata = 8'hC3;
        for (int e = 1; e <= 7; e++) begin
            step();
            e_ph = (e <= 2) ? e : ((e <= 5) ? 3 : 0);
            e_oe = (e >= 3 && e <= 5) ? 'hFF : 0;
            chk("t2_phase",   e, 16'(pad_phase2),  16'(e_ph));
            chk("t2_addr",    e, 16'(pad_addr2),   (e <= 5) ? 16'hFF : 16'h00);
            chk("t2_oe",      e, 16'(pad_io_oe2),  16'(e_oe));
            chk("t2_io_out",  e, 16'(pad_io_out2), (e_oe != 0) ? 16'hC3 : 16'h00);
            chk("t2_dbg_ack", e, 16'(dbg2.ack),    (e == 6) ? 16'h1 : 16'h0);
            chk("t2_cpu_ack", e, 16'(cpu2.ack),    16'h0);
            if (e == 6) dbg2.req = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
